// File: rtl/line_clear_controller.sv
// line_clear_controller
//
// Owns one port of the playfield row RAM while a line-clear scan runs.
// After start, rows are read from the bottom (ROWS-1) to the top (0).
// Full rows (all ones) are dropped, and surviving rows are copied down
// to close the gaps. The vacated top rows are then zero-filled, and the
// number of removed rows is reported.
//
// Ports:
//   Clock          system clock; every state update happens on its rising edge
//   reset          synchronous, active-high; aborts any scan in progress
//   start          begin a scan; only looked at while idle
//   busy           high in every state except idle
//   done           one-cycle pulse at the end of a scan
//   lines_cleared  rows removed by the last scan; held until the next start
//   ram_address    RAM port address
//   ram_rden       RAM read enable
//   ram_wren       RAM write enable (never high together with ram_rden)
//   ram_data       RAM write data
//   ram_q          RAM read data, READ_LATENCY cycles after the address

module line_clear_controller #(
    parameter int ROWS         = 24,
    parameter int WIDTH        = 12,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 2,
    parameter int CNT_W        = 5
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_cleared,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [WIDTH-1:0]  ram_data,
    input  logic [WIDTH-1:0]  ram_q
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int                LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] BOTTOM   = ADDR_W'(ROWS - 1);

    logic [2:0]        state,         state_nx;
    logic [ADDR_W-1:0] rd_ptr,        rd_nx;
    logic [ADDR_W-1:0] wr_ptr,        wr_nx;
    logic [WIDTH-1:0]  row_buf,       buf_nx;
    logic [LAT_W-1:0]  lat_cnt,       lat_nx;
    logic [CNT_W-1:0]  cnt,           cnt_nx;
    logic              src_exhausted, exh_nx;
    logic [CNT_W-1:0]  lines_nx;

    logic row_full;
    logic last_row;

    assign row_full = &row_buf;
    assign last_row = (rd_ptr == '0);

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        rd_nx    = rd_ptr;
        wr_nx    = wr_ptr;
        buf_nx   = row_buf;
        lat_nx   = lat_cnt;
        cnt_nx   = cnt;
        exh_nx   = src_exhausted;
        lines_nx = lines_cleared;

        case (state)
            S_IDLE: begin
                if (start) begin
                    rd_nx    = BOTTOM;
                    wr_nx    = BOTTOM;
                    cnt_nx   = '0;
                    lines_nx = '0;
                    lat_nx   = '0;
                    exh_nx   = 1'b0;
                    state_nx = S_READ;
                end
            end

            S_READ: begin
                if (lat_cnt == LAT_LAST) begin
                    buf_nx   = ram_q;
                    lat_nx   = '0;
                    state_nx = S_EVAL;
                end else begin
                    lat_nx = lat_cnt + 1'b1;
                end
            end

            S_EVAL: begin
                // The pointers are never stepped below row 0. Reaching the top
                // is tracked by last_row/src_exhausted, not by address wrap.
                if (row_full) begin
                    cnt_nx = cnt + 1'b1;
                    if (!last_row) rd_nx = rd_ptr - 1'b1;
                end else if (rd_ptr == wr_ptr) begin
                    if (!last_row) begin
                        rd_nx = rd_ptr - 1'b1;
                        wr_nx = wr_ptr - 1'b1;
                    end
                end

                if (last_row) exh_nx = 1'b1;

                if (!row_full && (rd_ptr != wr_ptr)) begin
                    state_nx = S_WRITE;
                end else if (last_row) begin
                    // A full row here means cnt_nx is nonzero, so a fill is needed.
                    state_nx = (row_full || (cnt != '0)) ? S_FILL : S_DONE;
                end else begin
                    state_nx = S_READ;
                end

                if (state_nx == S_DONE) lines_nx = cnt_nx;
            end

            S_WRITE: begin
                // After the last source row, wr_ptr lands on cnt-1, which is
                // the first row to zero-fill.
                wr_nx = wr_ptr - 1'b1;
                if (!src_exhausted) rd_nx = rd_ptr - 1'b1;
                state_nx = src_exhausted ? S_FILL : S_READ;
            end

            S_FILL: begin
                if (wr_ptr == '0) begin
                    lines_nx = cnt;
                    state_nx = S_DONE;
                end else begin
                    wr_nx = wr_ptr - 1'b1;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge Clock) begin
        if (reset) begin
            state         <= S_IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            row_buf       <= '0;
            lat_cnt       <= '0;
            cnt           <= '0;
            src_exhausted <= 1'b0;
            lines_cleared <= '0;
        end else begin
            state         <= state_nx;
            rd_ptr        <= rd_nx;
            wr_ptr        <= wr_nx;
            row_buf       <= buf_nx;
            lat_cnt       <= lat_nx;
            cnt           <= cnt_nx;
            src_exhausted <= exh_nx;
            lines_cleared <= lines_nx;
        end
    end

    // RAM port and status decode. Address and data are zero when the port is
    // not in use, so they read as zero during and straight after reset.
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_data    = '0;

        case (state)
            S_READ: begin
                ram_address = rd_ptr;
                ram_rden    = 1'b1;
            end
            S_WRITE: begin
                ram_address = wr_ptr;
                ram_data    = row_buf;
                ram_wren    = 1'b1;
            end
            S_FILL: begin
                ram_address = wr_ptr;
                ram_wren    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_line_clear_controller.sv
// Testbench for line_clear_controller.
// A RAM model with READ_LATENCY-1 output register stages sits on the port.
// Expected results are pushed to exp_q when a scan is launched. They are
// popped and compared once the scan has produced its outputs.

module tb_line_clear_controller;

    localparam int ROWS   = 24;
    localparam int WIDTH  = 12;
    localparam int ADDR_W = 5;
    localparam int RL     = 2;
    localparam int CNT_W  = 5;

    logic              Clock = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_cleared;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_rden;
    logic              ram_wren;
    logic [WIDTH-1:0]  ram_data;
    logic [WIDTH-1:0]  ram_q;

    always #5 Clock = ~Clock;

    line_clear_controller #(
        .ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
        .READ_LATENCY(RL), .CNT_W(CNT_W)
    ) dut (
        .Clock(Clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .ram_address(ram_address),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
    );

    // RAM model
    logic [WIDTH-1:0] mem    [0:31];
    logic [WIDTH-1:0] img    [0:ROWS-1];
    logic [WIDTH-1:0] q_pipe [0:RL-2];
    logic             load;

    always @(posedge Clock) begin
        if (load) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= img[i];
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
        if (ram_rden) q_pipe[0] <= mem[ram_address];
        for (int i = 1; i < RL - 1; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RL-2];

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int act_wr[$];
    int r_done, r_lines, r_lines_after, r_busy_after, r_conf, r_oob;

    task automatic load_image();
        load = 1'b1;
        @(posedge Clock);
        #1 load = 1'b0;
    endtask

    // Reference: expected done cycle and line count (test plan constants),
    // the full write trace, and the final RAM image.
    task automatic model_push(input int exp_done, input int exp_lines);
        logic [WIDTH-1:0] m [0:ROWS-1];
        int wl[$];
        int wr, cnt;
        wr = ROWS - 1;
        cnt = 0;
        for (int i = 0; i < ROWS; i++) m[i] = img[i];
        for (int rd = ROWS - 1; rd >= 0; rd--) begin
            if (img[rd] == '1) cnt++;
            else begin
                if (rd != wr) wl.push_back((wr << WIDTH) | int'(img[rd]));
                wr--;
            end
        end
        for (int a = cnt - 1; a >= 0; a--) wl.push_back(a << WIDTH);
        foreach (wl[k]) m[wl[k] >> WIDTH] = WIDTH'(wl[k]);
        exp_q.push_back(exp_done);
        exp_q.push_back(exp_lines);
        exp_q.push_back(wl.size());
        foreach (wl[k]) exp_q.push_back(wl[k]);
        for (int i = 0; i < ROWS; i++) exp_q.push_back(int'(m[i]));
    endtask

    // Launch a scan with start sampled at edge 0 and follow it to done.
    // Cycle n is the interval between edges n-1 and n.
    task automatic run_scan(input int repulse_cycle, input bit start_at_done);
        act_wr.delete();
        r_done = -1; r_lines = -1; r_lines_after = -1; r_busy_after = -1;
        r_conf = 0; r_oob = 0;
        @(negedge Clock);
        start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge Clock);
            start = (cyc == repulse_cycle);
            if (ram_rden && ram_wren) r_conf++;
            if ((ram_rden || ram_wren) && (int'(ram_address) >= ROWS)) r_oob++;
            if (ram_wren) act_wr.push_back(int'({ram_address, ram_data}));
            if (done) begin
                r_done  = cyc;
                r_lines = int'(lines_cleared);
                break;
            end
        end
        start = start_at_done;
        @(posedge Clock);
        #1 start = 1'b0;
        @(negedge Clock);
        r_busy_after  = int'(busy);
        r_lines_after = int'(lines_cleared);
    endtask

    task automatic test_reset();
        int e;
        for (int i = 0; i < 7; i++) exp_q.push_back(0);
        reset = 1'b1; start = 1'b0; load = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        e = exp_q.pop_front(); vectors++;
        if (int'(busy) !== e) begin miscompares++; $display("FAIL reset_busy: got %0d expected %0d", busy, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(done) !== e) begin miscompares++; $display("FAIL reset_done: got %0d expected %0d", done, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(ram_rden) !== e) begin miscompares++; $display("FAIL reset_rden: got %0d expected %0d", ram_rden, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(ram_wren) !== e) begin miscompares++; $display("FAIL reset_wren: got %0d expected %0d", ram_wren, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(ram_address) !== e) begin miscompares++; $display("FAIL reset_addr: got %0d expected %0d", ram_address, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(ram_data) !== e) begin miscompares++; $display("FAIL reset_data: got %0d expected %0d", ram_data, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(lines_cleared) !== e) begin miscompares++; $display("FAIL reset_lines: got %0d expected %0d", lines_cleared, e); end
    endtask

    // Pattern table: 0 empty, 1 single clear, 2 four stacked clears,
    // 3 interleaved clears, 4 full field, 5 as 1 with start re-pulsed
    // mid-scan and held high in the done cycle.
    task automatic test_scans();
        int done_t  [6] = '{73, 97, 97, 97, 97, 97};
        int lines_t [6] = '{0, 1, 4, 2, 24, 1};
        int e, n;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < ROWS; i++) img[i] = '0;
            case (p)
                1, 5: begin img[23] = 12'hFFF; img[22] = 12'h801; end
                2: begin
                    for (int i = 20; i < 24; i++) img[i] = 12'hFFF;
                    img[19] = 12'h0F0;
                end
                3: begin
                    img[23] = 12'hFFF; img[21] = 12'hFFF;
                    img[22] = 12'h001; img[20] = 12'h002;
                end
                4: for (int i = 0; i < ROWS; i++) img[i] = 12'hFFF;
                default: begin end
            endcase
            load_image();
            model_push(done_t[p], lines_t[p]);
            run_scan((p == 5) ? 30 : 0, p == 5);

            e = exp_q.pop_front(); vectors++;
            if (r_done !== e) begin miscompares++; $display("FAIL p%0d done_cycle: got %0d expected %0d", p, r_done, e); end
            e = exp_q.pop_front(); vectors++;
            if (r_lines !== e) begin miscompares++; $display("FAIL p%0d lines: got %0d expected %0d", p, r_lines, e); end
            vectors++;
            if (r_lines_after !== e) begin miscompares++; $display("FAIL p%0d lines_held: got %0d expected %0d", p, r_lines_after, e); end
            vectors++;
            if (r_busy_after !== 0) begin miscompares++; $display("FAIL p%0d busy_after_done: got %0d expected 0", p, r_busy_after); end
            vectors++;
            if (r_conf !== 0) begin miscompares++; $display("FAIL p%0d rden_wren_overlap: got %0d expected 0", p, r_conf); end
            vectors++;
            if (r_oob !== 0) begin miscompares++; $display("FAIL p%0d addr_out_of_range: got %0d expected 0", p, r_oob); end
            n = exp_q.pop_front(); vectors++;
            if (act_wr.size() !== n) begin miscompares++; $display("FAIL p%0d write_count: got %0d expected %0d", p, act_wr.size(), n); end
            for (int k = 0; k < n; k++) begin
                e = exp_q.pop_front(); vectors++;
                if (k >= act_wr.size() || act_wr[k] !== e) begin
                    miscompares++;
                    $display("FAIL p%0d write[%0d]: got %h expected %h", p, k, (k < act_wr.size()) ? act_wr[k] : -1, e);
                end
            end
            for (int i = 0; i < ROWS; i++) begin
                e = exp_q.pop_front(); vectors++;
                if (int'(mem[i]) !== e) begin miscompares++; $display("FAIL p%0d row%0d: got %h expected %h", p, i, mem[i], e); end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int e, first_wr, n;
        for (int i = 0; i < ROWS; i++) img[i] = 12'hFFF;
        load_image();
        exp_q.push_back(73);
        first_wr = -1;
        @(negedge Clock);
        start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge Clock);
            start = (cyc == 20);
            if (ram_wren) begin first_wr = cyc; break; end
        end
        start = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if (first_wr !== e) begin miscompares++; $display("FAIL first_fill_cycle: got %0d expected %0d", first_wr, e); end
        repeat (3) @(negedge Clock);
        reset = 1'b1;
        @(posedge Clock);
        #1 reset = 1'b0;
        @(negedge Clock);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0d expected 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %0d expected 0", done); end
        vectors++;
        if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL abort_wren: got %0d expected 0", ram_wren); end
        vectors++;
        if (lines_cleared !== '0) begin miscompares++; $display("FAIL abort_lines: got %0d expected 0", lines_cleared); end

        for (int i = 0; i < ROWS; i++) img[i] = '0;
        img[23] = 12'hFFF; img[22] = 12'h801;
        load_image();
        model_push(97, 1);
        run_scan(0, 1'b0);
        e = exp_q.pop_front(); vectors++;
        if (r_done !== e) begin miscompares++; $display("FAIL rerun_done_cycle: got %0d expected %0d", r_done, e); end
        e = exp_q.pop_front(); vectors++;
        if (r_lines !== e) begin miscompares++; $display("FAIL rerun_lines: got %0d expected %0d", r_lines, e); end
        n = exp_q.pop_front(); vectors++;
        if (act_wr.size() !== n) begin miscompares++; $display("FAIL rerun_write_count: got %0d expected %0d", act_wr.size(), n); end
        for (int k = 0; k < n; k++) void'(exp_q.pop_front());
        for (int i = 0; i < ROWS; i++) begin
            e = exp_q.pop_front(); vectors++;
            if (int'(mem[i]) !== e) begin miscompares++; $display("FAIL rerun_row%0d: got %h expected %h", i, mem[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_scans();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
